// File: rtl/sdram_pkg.sv
// Shared types and default geometry for the SDRAM request arbiter and controller.
package sdram_pkg;

    localparam int unsigned SDRAM_ADDR_W    = 25;
    localparam int unsigned SDRAM_DATA_W    = 16;
    localparam int unsigned SDRAM_BURST_LEN = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_VID
    } owner_t;

endpackage

// File: rtl/sdram_arb_if.sv
// Client and controller signals of the SDRAM arbiter.
// slave: arbiter view; master: the surrounding clients and controller.
interface sdram_arb_if
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W    = SDRAM_ADDR_W,
    parameter int unsigned DATA_W    = SDRAM_DATA_W,
    parameter int unsigned BURST_LEN = SDRAM_BURST_LEN
) ();

    logic                        cpu_req;
    logic                        cpu_write;
    logic [ADDR_W-1:0]           cpu_addr;
    logic [DATA_W-1:0]           cpu_wdata;
    logic [DATA_W-1:0]           cpu_rdata;
    logic                        cpu_done;

    logic                        vid_req;
    logic [ADDR_W-1:0]           vid_addr;
    logic [BURST_LEN*DATA_W-1:0] vid_line;
    logic                        vid_done;

    logic                        ctl_start;
    logic                        ctl_write_en;
    logic                        ctl_burst_en;
    logic [ADDR_W-1:0]           ctl_addr;
    logic [DATA_W-1:0]           ctl_data_in;
    logic                        ctl_rst_n_c;
    logic                        ctl_mem_ready;
    logic                        ctl_data_ready;
    logic [DATA_W-1:0]           ctl_data_out;
    logic [BURST_LEN*DATA_W-1:0] ctl_burst_buf;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  vid_req, vid_addr,
        output vid_line, vid_done,
        output ctl_start, ctl_write_en, ctl_burst_en, ctl_addr, ctl_data_in, ctl_rst_n_c,
        input  ctl_mem_ready, ctl_data_ready, ctl_data_out, ctl_burst_buf
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output vid_req, vid_addr,
        input  vid_line, vid_done,
        input  ctl_start, ctl_write_en, ctl_burst_en, ctl_addr, ctl_data_in, ctl_rst_n_c,
        output ctl_mem_ready, ctl_data_ready, ctl_data_out, ctl_burst_buf
    );

endinterface

// File: rtl/sdram_arb_prio.sv
// Winner select between CPU and video with a bounded video streak so the CPU is never starved.
module sdram_arb_prio
    import sdram_pkg::*;
#(
    parameter int unsigned MAX_VID_STREAK = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   cpu_req,
    input  logic   vid_req,
    input  logic   grant_en,
    output logic   grant_c,
    output owner_t winner_c
);

    localparam int unsigned STREAK_W = $clog2(MAX_VID_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

    logic [STREAK_W-1:0] streak;

    // Video wins by default; CPU wins when alone or once video has used up its streak.
    always_comb begin
        grant_c  = grant_en && (cpu_req || vid_req);
        winner_c = OWN_VID;
        if (cpu_req && (!vid_req || streak == STREAK_MAX)) begin
            winner_c = OWN_CPU;
        end
    end

    // Count video grants that bypassed a waiting CPU; any other grant restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_c) begin
            if (winner_c == OWN_CPU || !cpu_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_arb.sv
// Serialises CPU single-word and video burst requests onto the SDRAM controller.
// Optional macro SDRAM_ARB_PERF_EN adds grant and CPU wait-cycle counters.
module sdram_arb
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W         = SDRAM_ADDR_W,
    parameter int unsigned DATA_W         = SDRAM_DATA_W,
    parameter int unsigned BURST_LEN      = SDRAM_BURST_LEN,
    parameter int unsigned MAX_VID_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    sdram_arb_if.slave  bus
`ifdef SDRAM_ARB_PERF_EN
    ,
    output logic [31:0] perf_cpu_grants,
    output logic [31:0] perf_vid_grants,
    output logic [31:0] perf_cpu_wait
`endif
);

    localparam int unsigned LINE_W = BURST_LEN * DATA_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN - 1);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              start_q, start_d;
    logic              write_q, write_d;
    logic              burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              cpu_done_q, cpu_done_d;
    logic              vid_done_q, vid_done_d;
    logic              grant_c;
    owner_t            winner_c;

    sdram_arb_prio #(
        .MAX_VID_STREAK(MAX_VID_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (bus.cpu_req),
        .vid_req  (bus.vid_req),
        .grant_en (state_q == S_IDLE && bus.ctl_mem_ready),
        .grant_c  (grant_c),
        .winner_c (winner_c)
    );

    // Next-state and next-output logic; completion data is only accepted in S_WAIT.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        start_d    = 1'b0;
        write_d    = write_q;
        burst_d    = burst_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        line_d     = line_q;
        cpu_done_d = 1'b0;
        vid_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    owner_d = winner_c;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                    if (winner_c == OWN_VID) begin
                        addr_d  = bus.vid_addr & LINE_MASK;
                        write_d = 1'b0;
                        burst_d = 1'b1;
                    end else begin
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                        write_d = bus.cpu_write;
                        burst_d = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ctl_data_ready) begin
                    state_d = S_DONE;
                    write_d = 1'b0;
                    burst_d = 1'b0;
                    if (owner_q == OWN_VID) begin
                        line_d     = bus.ctl_burst_buf;
                        vid_done_d = 1'b1;
                    end else begin
                        if (!write_q) begin
                            rdata_d = bus.ctl_data_out;
                        end
                        cpu_done_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_CPU;
            start_q    <= 1'b0;
            write_q    <= 1'b0;
            burst_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            line_q     <= '0;
            cpu_done_q <= 1'b0;
            vid_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            start_q    <= start_d;
            write_q    <= write_d;
            burst_q    <= burst_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            line_q     <= line_d;
            cpu_done_q <= cpu_done_d;
            vid_done_q <= vid_done_d;
        end
    end

    assign bus.ctl_start    = start_q;
    assign bus.ctl_write_en = write_q;
    assign bus.ctl_burst_en = burst_q;
    assign bus.ctl_addr     = addr_q;
    assign bus.ctl_data_in  = wdata_q;
    assign bus.cpu_rdata    = rdata_q;
    assign bus.cpu_done     = cpu_done_q;
    assign bus.vid_line     = line_q;
    assign bus.vid_done     = vid_done_q;
    assign bus.ctl_rst_n_c  = ~rst;

`ifdef SDRAM_ARB_PERF_EN
    // Free-running grant and CPU wait-cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cpu_grants <= '0;
            perf_vid_grants <= '0;
            perf_cpu_wait   <= '0;
        end else begin
            if (grant_c && winner_c == OWN_CPU) begin
                perf_cpu_grants <= perf_cpu_grants + 32'd1;
            end
            if (grant_c && winner_c == OWN_VID) begin
                perf_vid_grants <= perf_vid_grants + 32'd1;
            end
            if (bus.cpu_req && !((state_q == S_WAIT || state_q == S_DONE) && owner_q == OWN_CPU)) begin
                perf_cpu_wait <= perf_cpu_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb with a behavioural controller model and scoreboards.
module tb_sdram_arb;
    import sdram_pkg::*;

    localparam int unsigned AW = SDRAM_ADDR_W;
    localparam int unsigned DW = SDRAM_DATA_W;
    localparam int unsigned BL = SDRAM_BURST_LEN;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sdram_arb_if bus ();

`ifdef SDRAM_ARB_PERF_EN
    logic [31:0] perf_cpu_grants, perf_vid_grants, perf_cpu_wait;
`endif

    sdram_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SDRAM_ARB_PERF_EN
        ,
        .perf_cpu_grants (perf_cpu_grants),
        .perf_vid_grants (perf_vid_grants),
        .perf_cpu_wait   (perf_cpu_wait)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic          be;
        logic [DW-1:0] wdata;
    } ctl_exp_t;

    ctl_exp_t      exp_ctl[$];
    logic [DW-1:0] exp_cpu[$];
    logic [DW-1:0] exp_vid[$];

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    logic          model_en = 1'b1;
    logic          model_dr = 1'b0;
    logic [DW-1:0] rd_val   = '0;
    logic [DW-1:0] vid_seed = 16'h0100;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Controller model: completes a started command three cycles later with a one-cycle ready.
    initial begin : ctl_model
        logic was_write;
        forever begin
            @(negedge clk);
            if (model_en && bus.ctl_start) begin
                was_write = bus.ctl_write_en;
                repeat (3) @(posedge clk);
                #1;
                bus.ctl_data_out = was_write ? 16'hDEAD : rd_val;
                for (int k = 0; k < BL; k++) bus.ctl_burst_buf[k*DW +: DW] = vid_seed + DW'(k);
                bus.ctl_data_ready = 1'b1;
                model_dr = 1'b1;
                @(posedge clk);
                #1;
                bus.ctl_data_ready = 1'b0;
                model_dr = 1'b0;
            end
        end
    end

    // Output monitor: compares commands and completions against the scoreboards.
    initial begin : monitor
        logic          prev_start, prev_cdone, prev_vdone, dr_pend;
        ctl_exp_t      e;
        logic [DW-1:0] base;
        logic [BL*DW-1:0] line;
        prev_start = 1'b0; prev_cdone = 1'b0; prev_vdone = 1'b0; dr_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (dr_pend) check("done_latency", 64'(bus.cpu_done | bus.vid_done), 1);
            dr_pend = model_dr;
            if (bus.ctl_start) begin
                start_cnt++;
                check("start_one_cycle", 64'(prev_start), 0);
                if (exp_ctl.size() == 0) begin
                    check("start_unexpected", 64'(bus.ctl_start), 0);
                end else begin
                    e = exp_ctl.pop_front();
                    check("ctl_addr", 64'(bus.ctl_addr), 64'(e.addr));
                    check("ctl_write_en", 64'(bus.ctl_write_en), 64'(e.we));
                    check("ctl_burst_en", 64'(bus.ctl_burst_en), 64'(e.be));
                    if (!e.be) check("ctl_data_in", 64'(bus.ctl_data_in), 64'(e.wdata));
                end
            end
            if (bus.cpu_done) begin
                check("cpu_done_one_cycle", 64'(prev_cdone), 0);
                if (exp_cpu.size() == 0) check("cpu_done_unexpected", 64'(bus.cpu_done), 0);
                else check("cpu_rdata", 64'(bus.cpu_rdata), 64'(exp_cpu.pop_front()));
            end
            if (bus.vid_done) begin
                check("vid_done_one_cycle", 64'(prev_vdone), 0);
                if (exp_vid.size() == 0) begin
                    check("vid_done_unexpected", 64'(bus.vid_done), 0);
                end else begin
                    base = exp_vid.pop_front();
                    for (int k = 0; k < BL; k++) line[k*DW +: DW] = base + DW'(k);
                    check("vid_word0", 64'(bus.vid_line[0 +: DW]), 64'(base));
                    check("vid_word31", 64'(bus.vid_line[(BL-1)*DW +: DW]), 64'(line[(BL-1)*DW +: DW]));
                    check("vid_line_all", 64'(bus.vid_line == line), 1);
                end
            end
            prev_start = bus.ctl_start;
            prev_cdone = bus.cpu_done;
            prev_vdone = bus.vid_done;
        end
    end

    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.ctl_start;
        end
        check(tag, 64'(seen), 1);
    endtask

    task automatic wait_done(input string tag, input bit vid);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = vid ? bus.vid_done : bus.cpu_done;
        end
        check(tag, 64'(seen), 1);
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rdata);
        exp_ctl.push_back('{addr: addr, we: we, be: 1'b0, wdata: wdata});
        exp_cpu.push_back(exp_rdata);
        bus.cpu_write = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_req   = 1'b1;
        wait_start("cpu_start_seen");
        bus.cpu_addr  = ~addr;
        bus.cpu_wdata = ~wdata;
        bus.cpu_write = ~we;
        wait_done("cpu_done_seen", 1'b0);
        bus.cpu_req = 1'b0;
    endtask

    task automatic vid_op(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr);
        exp_ctl.push_back('{addr: exp_addr, we: 1'b0, be: 1'b1, wdata: '0});
        exp_vid.push_back(vid_seed);
        bus.vid_addr = addr;
        bus.vid_req  = 1'b1;
        wait_start("vid_start_seen");
        bus.vid_addr = ~addr;
        wait_done("vid_done_seen", 1'b1);
        bus.vid_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl_start"}, 64'(bus.ctl_start), 0);
        check({tag, "_ctl_write_en"}, 64'(bus.ctl_write_en), 0);
        check({tag, "_ctl_burst_en"}, 64'(bus.ctl_burst_en), 0);
        check({tag, "_ctl_addr"}, 64'(bus.ctl_addr), 0);
        check({tag, "_ctl_data_in"}, 64'(bus.ctl_data_in), 0);
        check({tag, "_cpu_rdata"}, 64'(bus.cpu_rdata), 0);
        check({tag, "_cpu_done"}, 64'(bus.cpu_done), 0);
        check({tag, "_vid_line"}, 64'(bus.vid_line == '0), 1);
        check({tag, "_vid_done"}, 64'(bus.vid_done), 0);
        check({tag, "_ctl_rst_n"}, 64'(bus.ctl_rst_n_c), 0);
    endtask

    initial begin : stimulus
        int ndone;
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.ctl_mem_ready = 1'b0; bus.ctl_data_ready = 1'b0;
        bus.ctl_data_out = '0; bus.ctl_burst_buf = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // No grant while the controller is still initialising.
        exp_ctl.push_back('{addr: 25'h0012345, we: 1'b1, be: 1'b0, wdata: 16'hBEEF});
        exp_cpu.push_back(16'h0000);
        bus.cpu_write = 1'b1; bus.cpu_addr = 25'h0012345; bus.cpu_wdata = 16'hBEEF; bus.cpu_req = 1'b1;
        repeat (100) @(negedge clk);
        check("no_start_before_ready", 64'(start_cnt), 0);
        check("ctl_rst_n_released", 64'(bus.ctl_rst_n_c), 1);
        bus.ctl_mem_ready = 1'b1;
        @(negedge clk);
        check("start_after_ready", 64'(bus.ctl_start), 1);
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        wait_done("init_write_done", 1'b0);
        bus.cpu_req = 1'b0;

        // Single CPU read, then a write that must leave cpu_rdata alone.
        rd_val = 16'h5A5A;
        cpu_op(1'b0, 25'h0000777, 16'h0000, 16'h5A5A);
        cpu_op(1'b1, 25'h1ABCDEF, 16'h1234, 16'h5A5A);

        // Video bursts with line-aligned addresses.
        vid_seed = 16'h0100;
        vid_op(25'h0000413, 25'h0000400);
        vid_seed = 16'h2000;
        vid_op(25'h1FFFFFF, 25'h1FFFFE0);

        // Both clients held high: video streak of four then one CPU grant, twice.
        rd_val = 16'h0C0C;
        vid_seed = 16'h0300;
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 4; v++) begin
                exp_ctl.push_back('{addr: 25'h0000800, we: 1'b0, be: 1'b1, wdata: '0});
                exp_vid.push_back(16'h0300);
            end
            exp_ctl.push_back('{addr: 25'h0000100, we: 1'b0, be: 1'b0, wdata: '0});
            exp_cpu.push_back(16'h0C0C);
        end
        bus.cpu_write = 1'b0; bus.cpu_addr = 25'h0000100; bus.cpu_wdata = '0;
        bus.vid_addr = 25'h0000800;
        bus.cpu_req = 1'b1; bus.vid_req = 1'b1;
        ndone = 0;
        for (int i = 0; i < 2000 && ndone < 10; i++) begin
            @(negedge clk);
            if (bus.cpu_done || bus.vid_done) ndone++;
        end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        check("starve_done_count", 64'(ndone), 10);
        check("starve_ctl_drained", 64'(exp_ctl.size()), 0);

        // Stray ready in S_ISSUE, then reset while waiting: no completion must appear.
        model_en = 1'b0;
        exp_ctl.push_back('{addr: 25'h0000055, we: 1'b0, be: 1'b0, wdata: '0});
        bus.cpu_write = 1'b0; bus.cpu_addr = 25'h0000055; bus.cpu_req = 1'b1;
        wait_start("reset_case_start");
        bus.ctl_data_out = 16'h9999;
        bus.ctl_data_ready = 1'b1;
        @(negedge clk);
        bus.ctl_data_ready = 1'b0;
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.cpu_done) ndone++;
        end
        check("ready_in_issue_ignored", 64'(ndone), 0);
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        @(negedge clk);
        bus.ctl_data_ready = 1'b1;
        @(negedge clk);
        bus.ctl_data_ready = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.cpu_done || bus.vid_done) ndone++;
        end
        check("no_done_after_reset", 64'(ndone), 0);
        check("rdata_after_reset", 64'(bus.cpu_rdata), 0);

        // Normal traffic resumes after reset.
        model_en = 1'b1;
        rd_val = 16'h7777;
        cpu_op(1'b0, 25'h0000066, 16'h0000, 16'h7777);
        repeat (4) @(negedge clk);
        check("queues_empty", 64'(exp_ctl.size() + exp_cpu.size() + exp_vid.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
- Request arbiter directly upstream of the SDRAM controller.
- Clients: the CPU memory port (single-word read/write) and the video line fetcher (32-word burst read).
- Serialises client requests into the controller's start/addr/write_en/burst_en interface and waits for the controller's completion pulse.
- Returns read data or the burst line to the granted client with a one-cycle done pulse.

Parameters:
- ADDR_W, 25, SDRAM word address width ({bank, row, column}).
- DATA_W, 16, SDRAM data width.
- BURST_LEN, 32, words per video burst.
- MAX_VID_STREAK, 4, max consecutive video grants while a CPU request waits.

Ports:
- clk  in  1  system clock; controller clock is identical.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request level; held until cpu_done.
- cpu_write  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid from the cpu_done cycle until the next CPU read completes.
- cpu_done  out  1  one-cycle completion pulse.
- vid_req  in  1  video line request level; held until vid_done.
- vid_addr  in  ADDR_W  line start address; bits [4:0] ignored.
- vid_line  out  BURST_LEN*DATA_W  burst line, word i at [i*DATA_W +: DATA_W].
- vid_done  out  1  one-cycle completion pulse.
- ctl_start  out  1  start strobe; drives the controller's refresh_data.
- ctl_write_en  out  1  to controller write_en.
- ctl_burst_en  out  1  to controller burst_en.
- ctl_addr  out  ADDR_W  to controller addr.
- ctl_data_in  out  DATA_W  to controller data_in.
- ctl_mem_ready  in  1  controller has finished init.
- ctl_data_ready  in  1  controller completion; high exactly one cycle.
- ctl_data_out  in  DATA_W  single-read result.
- ctl_burst_buf  in  BURST_LEN*DATA_W  burst result.

Behaviour:
- Reset values:
  - All outputs 0: ctl_start, ctl_write_en, ctl_burst_en, ctl_addr, ctl_data_in, cpu_rdata, cpu_done, vid_line, vid_done.
  - State S_IDLE; streak counter 0.
- S_IDLE:
  - No grant while ctl_mem_ready=0.
  - Otherwise choose a winner.
  - Priority: video wins unless cpu_req=1 and streak==MAX_VID_STREAK, in which case CPU wins.
- Latching at grant:
  - Address, write flag and write data are latched into ctl_* registers; clients may change inputs after grant.
  - Video grants force ctl_addr[4:0]=0, ctl_write_en=0, ctl_burst_en=1.
  - CPU grants set ctl_burst_en=0.
  - Go to S_ISSUE.
- Streak counter:
  - Increments (saturating at MAX_VID_STREAK) on each video grant made while cpu_req=1.
  - Clears on any CPU grant, or on a video grant made while cpu_req=0.
- S_ISSUE: ctl_start=1 for exactly this one cycle; go to S_WAIT.
- S_WAIT:
  - ctl_* held constant.
  - On ctl_data_ready=1, capture the result:
    - CPU read: cpu_rdata<=ctl_data_out.
    - Video: vid_line<=ctl_burst_buf.
    - CPU write: cpu_rdata unchanged.
  - Go to S_DONE.
- S_DONE:
  - Pulse the granted client's done for one cycle.
  - ctl_burst_en and ctl_write_en cleared.
  - Go to S_IDLE.
  - New grant earliest the next cycle, so ctl_start is never high while the controller is outside its idle state.
- Latency:
  - Grant to ctl_start: 1 cycle.
  - ctl_data_ready to done: 1 cycle.
  - Back-to-back requests: 2 idle cycles between completions (DONE, IDLE grant).
- Boundary conditions:
  - Simultaneous requests with streak<MAX: video wins.
  - Client deasserts req mid-transaction: transaction completes; done still pulses.
  - ctl_data_ready seen in S_IDLE or S_ISSUE: ignored.
  - Reset mid-transaction: return to S_IDLE; no done pulse.
- Reset sharing: the top level derives the controller's active-low reset from the same rst, so both restart together.

Optional Feature:
- Macro SDRAM_ARB_PERF_EN.
- With it, adds three 32-bit outputs, cleared on rst, wrapping at 2^32:
  - perf_cpu_grants: +1 per CPU grant.
  - perf_vid_grants: +1 per video grant.
  - perf_cpu_wait: +1 each cycle cpu_req=1 and state≠S_WAIT/S_DONE for a CPU grant.
- Without it: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package sdram_pkg:
  - Arbiter state enum (S_IDLE, S_ISSUE, S_WAIT, S_DONE).
  - Grant-owner enum (OWN_CPU, OWN_VID).
  - ADDR_W/DATA_W/BURST_LEN defaults, shared with the controller.
- Sub-module sdram_arb_prio: combinational winner select plus the registered streak counter.

Test Plan:
- Init: hold ctl_mem_ready=0 with cpu_req=1 for 100 cycles -> no ctl_start. Raise ctl_mem_ready -> ctl_start one cycle after the grant.
- CPU write: addr 0x0012345, wdata 0xBEEF -> ctl_addr=0x0012345, ctl_write_en=1, ctl_burst_en=0, ctl_start for one cycle. Model returns ctl_data_ready -> cpu_done next cycle; cpu_rdata unchanged.
- CPU read: model returns ctl_data_out=0x5A5A -> cpu_rdata=0x5A5A with cpu_done.
- Video read: vid_addr=0x0000413 -> ctl_addr=0x0000400, ctl_burst_en=1. Burst words k=0..31 =0x100+k -> vid_line word 31=0x11F with vid_done.
- Starvation: vid_req and cpu_req held high continuously -> grant order V,V,V,V,C,V,V,V,V,C.
- Reset in S_WAIT -> all outputs 0, no done pulse. A later ctl_data_ready is ignored; the next request completes normally.
